// File: rtl/des_pkg.sv
// Shared DES constants: expansion and permutation tables, S-box slicing helpers
// and the skid-buffer state encoding used by the round feeder.
package des_pkg;

    localparam int unsigned SBOX_W   = 6;
    localparam int unsigned NUM_SBOX = 8;
    localparam int unsigned R_W      = 32;
    localparam int unsigned E_W      = SBOX_W * NUM_SBOX;

    // Output bit k (1-based, MSB first) of E is DES R bit E_TABLE[k-1].
    localparam int unsigned E_TABLE [E_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    // P permutation applied after the S-boxes by the downstream stage.
    localparam int unsigned P_TABLE [R_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Encoding is {main_v, skid_v}; (0,1) is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } skid_state_t;

    // LSB position of the 6-bit address for S-box idx (0 = S1 ... 7 = S8).
    function automatic int unsigned sbox_lsb(input int unsigned idx);
        return E_W - SBOX_W * (idx + 1);
    endfunction

endpackage

// File: rtl/des_e_expand.sv
// Combinational DES E expansion, 32 -> 48 bits. Bit n of the DES numbering
// sits at vector index (width - n) on both sides.
module des_e_expand
    import des_pkg::*;
(
    input  logic [R_W-1:0] r_in,
    output logic [E_W-1:0] e_out
);

    // Pure wiring: each output bit picks one input bit from the E table.
    for (genvar k = 0; k < E_W; k++) begin : g_bit
        assign e_out[E_W-1-k] = r_in[R_W-E_TABLE[k]];
    end

endmodule

// File: rtl/des_expand_mix.sv
// Feistel round feeder: E(R) xor K registered behind a valid/ready handshake,
// producing the 48-bit address bundle for S1..S8.
module des_expand_mix
    import des_pkg::*;
#(
    parameter int unsigned SKID = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [R_W-1:0] r_half,
    input  logic [E_W-1:0] subkey,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [E_W-1:0] sbox_addr
);

    logic [E_W-1:0] e_r;
    logic [E_W-1:0] mix;

    des_e_expand u_e_expand (
        .r_in  (r_half),
        .e_out (e_r)
    );

    assign mix = e_r ^ subkey;

    if (SKID != 0) begin : g_skid
        skid_state_t    state;
        logic [E_W-1:0] main_q;
        logic [E_W-1:0] skid_q;

        // in_ready depends only on the state flop, never on out_ready.
        assign in_ready  = (state != StFull);
        assign out_valid = state[1];
        assign sbox_addr = main_q;

        // Two-entry skid FSM; data registers load only on a transfer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= StEmpty;
                main_q <= '0;
                skid_q <= '0;
            end else begin
                unique case (state)
                    StEmpty: begin
                        if (in_valid) begin
                            main_q <= mix;
                            state  <= StOne;
                        end
                    end
                    StOne: begin
                        if (in_valid && out_ready) begin
                            main_q <= mix;
                        end else if (in_valid) begin
                            skid_q <= mix;
                            state  <= StFull;
                        end else if (out_ready) begin
                            state  <= StEmpty;
                        end
                    end
                    StFull: begin
                        if (out_ready) begin
                            main_q <= skid_q;
                            state  <= StOne;
                        end
                    end
                    default: state <= StEmpty;
                endcase
            end
        end
    end else begin : g_single
        logic           v_q;
        logic [E_W-1:0] d_q;

        // Combinational ready: a draining consumer frees the register this cycle.
        assign in_ready  = !v_q || out_ready;
        assign out_valid = v_q;
        assign sbox_addr = d_q;

        // Single output register with load-on-accept, clear-on-drain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (in_valid && in_ready) begin
                v_q <= 1'b1;
                d_q <= mix;
            end else if (out_ready) begin
                v_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_expand_mix.sv
// Bench for des_expand_mix: scoreboarded E/XOR model, stall/drain, streaming,
// async reset and an S3 table lookup on the produced addresses.
module tb_des_expand_mix;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r_half;
    logic [47:0] subkey;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] sbox_addr;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_q [$];
    logic [47:0] got_q [$];
    int          got_cyc [$];
    logic [31:0] rq [$];
    logic [47:0] kq [$];

    localparam int ETAB [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };

    localparam int S3 [64] = '{
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12
    };

    des_expand_mix #(.SKID(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_half    (r_half),
        .subkey    (subkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sbox_addr (sbox_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-ETAB[i]];
        return e ^ k;
    endfunction

    function automatic int s3_of(input logic [47:0] a);
        logic [5:0] s;
        int row;
        int col;
        s   = a[35:30];
        row = {30'd0, s[5], s[0]};
        col = {28'd0, s[4:1]};
        return S3[row*16+col];
    endfunction

    // Streams rq/kq with out_ready held high; records outputs with cycle index.
    task automatic drive_stream(input int n);
        int idx;
        idx = 0;
        got_q.delete();
        got_cyc.delete();
        for (int cyc = 0; cyc < n + 4; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            if (idx < n) begin
                r_half   = rq[idx];
                subkey   = kq[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_q.push_back(sbox_addr);
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(r_half, subkey));
                idx++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; r_half = '0; subkey = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (sbox_addr !== 48'h0) begin
            failures++; $display("FAIL reset_sbox_addr: got %h expected 0", sbox_addr);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] rv [3];
        logic [47:0] kv [3];
        logic [47:0] xv [3];
        logic [47:0] e;
        rv = '{32'h00000001, 32'h80000000, 32'h0};
        kv = '{48'h0, 48'h0, 48'hFFFFFFFFFFFF};
        xv = '{48'h800000000002, 48'h400000000001, 48'hFFFFFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            r_half = rv[i]; subkey = kv[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(xv[i]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL vec%0d_valid: got %b expected 1", i, out_valid);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL vec%0d_accept: got no accept expected one", i);
            end else begin
                e = exp_q.pop_front();
                if (sbox_addr !== e) begin
                    failures++; $display("FAIL vec%0d_addr: got %h expected %h", i, sbox_addr, e);
                end
            end
            if (i == 0) begin
                checks++;
                if (sbox_addr[47:42] !== 6'b100000) begin
                    failures++; $display("FAIL vec0_s1: got %b expected 100000", sbox_addr[47:42]);
                end
                checks++;
                if (sbox_addr[5:0] !== 6'b000010) begin
                    failures++; $display("FAIL vec0_s8: got %b expected 000010", sbox_addr[5:0]);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [47:0] e;
        int drained;
        @(posedge clk);
        #1;
        r_half = 32'h12345678; subkey = 48'hA5A5_0F0F_3C3C; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(r_half, subkey));
        @(posedge clk);
        #1;
        r_half = 32'hDEADBEEF; subkey = 48'h0123_4567_89AB;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(r_half, subkey));
        @(posedge clk);
        #1;
        r_half = 32'hFFFF0000; subkey = 48'h1;  // offered while full; must be ignored
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(model(r_half, subkey));
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0 || out_valid !== 1'b1 || sbox_addr !== exp_q[0]) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b %h expected v=1 first result", c, out_valid,
                         sbox_addr);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drained = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                drained++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stall_extra: got %h expected nothing", sbox_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (sbox_addr !== e) begin
                        failures++;
                        $display("FAIL stall_drain%0d: got %h expected %h", drained, sbox_addr, e);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (drained != 2) begin
            failures++; $display("FAIL stall_count: got %0d expected 2", drained);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_in_ready_back: got %b expected 1", in_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [47:0] e;
        rq.delete(); kq.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            rq.push_back($urandom);
            kq.push_back({16'($urandom), 32'($urandom)});
        end
        drive_stream(16);
        checks++;
        if (got_q.size() != 16) begin
            failures++; $display("FAIL b2b_count: got %0d expected 16", got_q.size());
        end else begin
            checks++;
            if (got_cyc[15] - got_cyc[0] != 15) begin
                failures++;
                $display("FAIL b2b_span: got %0d expected 15", got_cyc[15] - got_cyc[0]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                failures++; $display("FAIL b2b_item%0d: got missing expected an output", i);
            end else begin
                e = exp_q.pop_front();
                if (got_q[0] !== e) begin
                    failures++; $display("FAIL b2b_item%0d: got %h expected %h", i, got_q[0], e);
                end
                void'(got_q.pop_front());
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_full();
        logic saw_valid;
        @(posedge clk);
        #1;
        r_half = 32'hCAFEF00D; subkey = 48'h5555_AAAA_5555; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        r_half = 32'h0BADF00D;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_full_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_full_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (sbox_addr !== 48'h0) begin
            failures++; $display("FAIL rst_full_addr: got %h expected 0", sbox_addr);
        end
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            failures++; $display("FAIL rst_full_stale: got out_valid=1 expected 0");
        end
    endtask

    task automatic test_sbox3();
        logic [47:0] e;
        rq.delete(); kq.delete(); exp_q.delete();
        rq.push_back(32'h0); kq.push_back(48'h0);
        rq.push_back(32'h0); kq.push_back(48'h000FC0000000);
        for (int i = 0; i < 6; i++) begin
            rq.push_back($urandom);
            kq.push_back({16'($urandom), 32'($urandom)});
        end
        drive_stream(8);
        checks++;
        if (got_q.size() != 8) begin
            failures++; $display("FAIL s3_count: got %0d expected 8", got_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (got_q.size() != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (s3_of(got_q[0]) != s3_of(e)) begin
                    failures++;
                    $display("FAIL s3_item%0d: got %0d expected %0d", i, s3_of(got_q[0]), s3_of(e));
                end
                if (i < 2) begin
                    checks++;
                    if (s3_of(got_q[0]) != ((i == 0) ? 10 : 12)) begin
                        failures++;
                        $display("FAIL s3_known%0d: got %0d expected %0d", i, s3_of(got_q[0]),
                                 (i == 0) ? 10 : 12);
                    end
                end
                void'(got_q.pop_front());
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_back_to_back();
        test_reset_full();
        test_sbox3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
